sobel_line_scheduler: RTL
=========================

Name: sobel_line_scheduler

Overview:
Sits between the Sobel filter output and the Ethernet transmit path, in the halved pixel-clock domain. Packs the 1-bit Sobel stream 8 pixels per byte into a ping-pong line buffer. Schedules one packet per completed image line onto a byte stream with a valid/ready handshake. Each packet is a 2-byte row index followed by IMAGE_WIDTH/8 payload bytes (DATA_LENGTH bytes in total); the downstream async FIFO/UDP framer consumes it.

Parameters:
IMAGE_WIDTH, 1280, pixels per line; must be a multiple of 8.
IMAGE_HEIGHT, 720, lines per frame.
LINE_BYTES, IMAGE_WIDTH/8, payload bytes per packet.
DATA_LENGTH, LINE_BYTES+2, bytes per packet.

Ports:
clk  in  1  halved pixel clock; the only clock.
rst_p  in  1  asynchronous, active-high reset.
sobel  in  1  Sobel edge bit (1 = edge).
sobel_valid  in  1  sobel bit valid this cycle.
sobel_vsync  in  1  frame sync; a rising edge marks frame start.
tx_ready  in  1  downstream accepts tx_data.
tx_valid  out  1  tx_data valid.
tx_data  out  8  packet byte.
tx_sof  out  1  first byte of a packet (qualified by tx_valid).
tx_eof  out  1  last byte of a packet (qualified by tx_valid).
line_drop  out  1  one-cycle pulse when a completed line is discarded.
drop_cnt  out  16  saturating count of dropped lines; cleared at frame start.
busy  out  1  at least one bank full, or a packet in flight.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst_p.
- Reset values: all outputs 0. Both banks empty; pixel, byte and row counters 0; reader in IDLE.
- Frame start:
  - Detect the vsync rising edge with a 1-cycle registered compare.
  - On that edge: row counter = 0, pixel counter = 0, discard any partial packing byte, drop_cnt = 0.
  - Banks already full are still transmitted.
- Packing: on each sobel_valid, shift the bit into the pack register, MSB first, so pixel 0 lands in bit 7.
- Byte write: every 8th valid pixel writes the byte to wr_bank[byte_idx].
- Line end: on the IMAGE_WIDTH-th valid pixel:
  - If the bank being written is writable, mark it full and latch row into its tag; wr_bank toggles.
  - Otherwise, pulse line_drop and increment drop_cnt, saturating at 0xFFFF.
  - In both cases the row counter increments.
- Bank writability: the target bank's full flag is sampled at pixel 0 of the line. If that bank is full, the whole line is dropped, even if the bank frees up mid-line.
- Row index: wraps to 0 after IMAGE_HEIGHT-1. Valid pixels beyond IMAGE_HEIGHT lines before the next vsync are still packetized with the wrapped index.
- Reader FSM:
  - IDLE -> HDR_HI when rd_bank is full.
  - HDR_HI: tx_data = {6'b0, row[9:8]} (row tag bits 15:8), tx_sof = 1.
  - HDR_LO: tx_data = row[7:0].
  - PAYLOAD: bytes 0..LINE_BYTES-1; tx_eof on the last byte.
  - DONE: clear full[rd_bank], toggle rd_bank, -> IDLE.
  - Each state advances only on tx_valid && tx_ready.
- Latency: tx_valid asserts no more than 2 clk after the line's last valid pixel when the reader is idle. With tx_ready held high, bytes are back-to-back, 1 per cycle. Packet boundaries may insert up to 2 idle cycles.
- Handshake rules:
  - Once tx_valid is asserted, tx_data, tx_sof and tx_eof stay stable until accepted.
  - tx_valid never deasserts without acceptance, except on reset.
  - The RAM may be synchronous-read with a 1-byte prefetch/skid register, as long as these rules hold.
- Simultaneous events:
  - A line end and DONE in the same cycle on different banks are both honoured.
  - The full-flag set and clear use separate bank indices, so they never conflict.
- Mid-frame vsync edge: a partial line is discarded silently, with no line_drop.
- Reset mid-packet: tx_valid drops immediately. The downstream framer must discard any unterminated packet.

Decomposition:
- Shared package holds:
  - packet header layout constants: HDR_BYTES = 2, ROW_W = 16;
  - reader state encoding: IDLE, HDR_HI, HDR_LO, PAYLOAD, DONE;
  - LINE_BYTES / DATA_LENGTH derivation, also used by the Ethernet framer.
- One sub-module, line_pingpong_ram: 2 x LINE_BYTES x 8 simple dual-port RAM (1 write, 1 sync read port), inferred as distributed or block RAM.

Test Plan:
All scenarios use IMAGE_WIDTH=32, IMAGE_HEIGHT=4 (LINE_BYTES=4, DATA_LENGTH=6).
1. Reset, vsync rise, one line of pattern 0xA5,0x0F,0xFF,0x00 with tx_ready=1 -> 6 bytes 00,00,A5,0F,FF,00; sof on byte 0, eof on byte 5; first tx_valid ≤ 2 cycles after the last pixel.
2. Four lines, tx_ready=1 -> headers 0000,0001,0002,0003; a 5th line before vsync -> header 0000 (wrap).
3. tx_ready=0 while 3 lines arrive -> lines 0 and 1 buffered; line 2 dropped (line_drop one pulse, drop_cnt=1). Release ready -> rows 0,1 sent intact; no row-2 packet.
4. tx_ready toggling 1/0 every cycle -> tx_data/sof/eof stable while stalled; byte sequence identical to scenario 1.
5. vsync rising after 17 pixels of a line -> no packet, no line_drop. The next full line is sent with header 0000; drop_cnt cleared to 0.
6. Assert rst_p during the PAYLOAD byte 2 handshake -> all outputs 0 asynchronously. After release plus a new line, a fresh packet starts with sof and header 0000.

Source files
------------

// File: rtl/sobel_line_scheduler_pkg.sv
// Shared types and packet layout for the Sobel line packetizer
// and the downstream Ethernet framer.
package sobel_line_scheduler_pkg;

    localparam int HDR_BYTES = 2;
    localparam int ROW_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        PAYLOAD,
        DONE
    } rd_state_t;

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eof;
    } tx_beat_t;

    function automatic int line_bytes(input int width);
        return width / 8;
    endfunction

    function automatic int data_length(input int width);
        return line_bytes(width) + HDR_BYTES;
    endfunction

endpackage

// File: rtl/sobel_line_scheduler_ram.sv
// Two-bank line store: one write port, one registered read port.
module line_pingpong_ram #(
    parameter int LINE_BYTES = 160,
    parameter int AW         = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic          wbank,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          rbank,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [2][LINE_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wbank][waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        rdata <= mem[rbank][raddr];
    end

endmodule

// File: rtl/sobel_line_scheduler.sv
// Packs the 1-bit Sobel stream into a ping-pong line store and
// emits one row-tagged packet per completed line.
module sobel_line_scheduler
    import sobel_line_scheduler_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 1280,
    parameter int IMAGE_HEIGHT = 720
) (
    input  logic        clk,
    input  logic        rst_p,
    input  logic        sobel,
    input  logic        sobel_valid,
    input  logic        sobel_vsync,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_sof,
    output logic        tx_eof,
    output logic        line_drop,
    output logic [15:0] drop_cnt,
    output logic        busy
);

    localparam int LINE_BYTES = line_bytes(IMAGE_WIDTH);
    localparam int PIX_W      = $clog2(IMAGE_WIDTH);
    localparam int AW         = PIX_W - 3;

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(IMAGE_WIDTH - 1);
    localparam logic [AW-1:0]    IDX_LAST = AW'(LINE_BYTES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);

    logic             vsync_q;
    logic             vs_rise;
    logic [PIX_W-1:0] pix;
    logic [7:0]       pack;
    logic [7:0]       pack_nxt;
    logic [ROW_W-1:0] row;
    logic             wr_bank;
    logic             line_ok_q;
    logic             line_ok;
    logic             ram_we;
    logic             line_end;
    logic             set_full;
    logic             clr_full;
    logic [1:0]       full;
    logic [ROW_W-1:0] tag [2];

    rd_state_t        state;
    logic             rd_bank;
    logic [AW-1:0]    rd_idx;
    logic [AW-1:0]    raddr;
    logic [7:0]       rdata;
    logic             accept;
    tx_beat_t         beat;

    assign vs_rise  = sobel_vsync & ~vsync_q;
    assign pack_nxt = {pack[6:0], sobel};

    // Writability is decided once, at pixel 0, and held for the line.
    assign line_ok  = (pix == '0) ? ~full[wr_bank] : line_ok_q;
    assign ram_we   = sobel_valid & ~vs_rise & line_ok & (pix[2:0] == 3'd7);
    assign line_end = sobel_valid & ~vs_rise & (pix == PIX_LAST);
    assign set_full = line_end & line_ok;
    assign clr_full = (state == DONE);

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            vsync_q   <= 1'b0;
            pix       <= '0;
            pack      <= '0;
            row       <= '0;
            wr_bank   <= 1'b0;
            line_ok_q <= 1'b0;
            line_drop <= 1'b0;
            drop_cnt  <= '0;
            tag       <= '{default: '0};
        end else begin
            vsync_q   <= sobel_vsync;
            line_drop <= 1'b0;
            if (vs_rise) begin
                pix      <= '0;
                pack     <= '0;
                row      <= '0;
                drop_cnt <= '0;
            end else if (sobel_valid) begin
                pack      <= pack_nxt;
                line_ok_q <= line_ok;
                if (line_end) begin
                    pix <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                    if (line_ok) begin
                        tag[wr_bank] <= row;
                        wr_bank      <= ~wr_bank;
                    end else begin
                        line_drop <= 1'b1;
                        if (drop_cnt != 16'hFFFF) begin
                            drop_cnt <= drop_cnt + 1'b1;
                        end
                    end
                end else begin
                    pix <= pix + 1'b1;
                end
            end
        end
    end

    // Set and clear always target different banks.
    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            full <= '0;
        end else begin
            if (set_full) full[wr_bank] <= 1'b1;
            if (clr_full) full[rd_bank] <= 1'b0;
        end
    end

    line_pingpong_ram #(
        .LINE_BYTES(LINE_BYTES),
        .AW        (AW)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .wbank(wr_bank),
        .waddr(pix[PIX_W-1:3]),
        .wdata(pack_nxt),
        .rbank(rd_bank),
        .raddr(raddr),
        .rdata(rdata)
    );

    assign accept = tx_valid & tx_ready;

    // Look-ahead address keeps rdata == mem[rd_idx] every cycle.
    always_comb begin
        raddr = rd_idx;
        if (state == IDLE || state == DONE) begin
            raddr = '0;
        end else if (accept && (state == HDR_LO || state == PAYLOAD)
                     && rd_idx != IDX_LAST) begin
            raddr = rd_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state    <= IDLE;
            rd_bank  <= 1'b0;
            rd_idx   <= '0;
            beat     <= '0;
            tx_valid <= 1'b0;
        end else begin
            rd_idx <= raddr;
            unique case (state)
                IDLE: begin
                    if (full[rd_bank]) begin
                        tx_valid <= 1'b1;
                        beat     <= '{data: tag[rd_bank][15:8],
                                      sof: 1'b1, eof: 1'b0};
                        state    <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (accept) begin
                        beat  <= '{data: tag[rd_bank][7:0],
                                   sof: 1'b0, eof: 1'b0};
                        state <= HDR_LO;
                    end
                end
                HDR_LO: begin
                    if (accept) begin
                        beat  <= '{data: rdata, sof: 1'b0,
                                   eof: (rd_idx == IDX_LAST)};
                        state <= PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        if (beat.eof) begin
                            tx_valid <= 1'b0;
                            beat     <= '0;
                            state    <= DONE;
                        end else begin
                            beat <= '{data: rdata, sof: 1'b0,
                                      eof: (rd_idx == IDX_LAST)};
                        end
                    end
                end
                DONE: begin
                    rd_bank <= ~rd_bank;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign tx_data = beat.data;
    assign tx_sof  = beat.sof;
    assign tx_eof  = beat.eof;
    assign busy    = (|full) | (state != IDLE);

endmodule
